pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_wait_watchdog.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer: FSM state encoding
// and the default watchdog limit.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/pipe_wait_watchdog.sv
// Memory-wait cycle counter with saturation and a sticky timeout flag.
// The counter reads 1 on the first MEM_WAIT cycle and 0 whenever the core runs.
module pipe_wait_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    input  logic mem_stall,
    output logic err_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (mem_stall) begin
            if (!in_wait)
                wait_cnt <= CNT_W'(1);
            else if (wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky until reset; the FSM is never forced out of MEM_WAIT by this flag.
    always_ff @(posedge clk) begin
        if (rst)
            err_timeout <= 1'b0;
        else if (in_wait && (wait_cnt == TIMEOUT_VAL))
            err_timeout <= 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush decode for PC and stage registers plus the
// memory-wait FSM. Optional perf counters under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             id_freeze,
    output logic             exe_freeze,
    output logic             mem_freeze,
    output logic             mem_busy,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             err_timeout
);

    ctrl_state_t state;
    logic        mem_stall;

    // Handshake: mem_req is the MEM stage's valid; the access completes in any
    // cycle where mem_req && mem_ready. Valid without ready stalls the whole pipe.
    assign mem_stall = mem_req & ~mem_ready;
    assign mem_busy  = (state == MEM_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (mem_stall)  state <= MEM_WAIT;
                MEM_WAIT: if (!mem_stall) state <= RUN;
                default:                  state <= RUN;
            endcase
        end
    end

    // A branch seen during a stall is held in EXE/MEM and serviced afterwards.
    always_comb begin
        pc_freeze  = 1'b0;
        if_freeze  = 1'b0;
        if_flush   = 1'b0;
        id_flush   = 1'b0;
        id_freeze  = 1'b0;
        exe_freeze = 1'b0;
        mem_freeze = 1'b0;
        if (mem_stall) begin
            pc_freeze  = 1'b1;
            if_freeze  = 1'b1;
            id_freeze  = 1'b1;
            exe_freeze = 1'b1;
            mem_freeze = 1'b1;
        end else if (branch_taken) begin
            if_flush   = 1'b1;
            id_flush   = 1'b1;
        end else if (hazard) begin
            pc_freeze  = 1'b1;
            if_freeze  = 1'b1;
            id_flush   = 1'b1;
        end
    end

    pipe_wait_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .in_wait     (mem_busy),
        .mem_stall   (mem_stall),
        .err_timeout (err_timeout)
    );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // pc_freeze is high exactly on memory-stall or load-use cycles; if_flush on serviced branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_freeze && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan sequences plus
// random traffic, each cycle's expected outputs queued and compared at negedge.
module tb_pipe_hazard_ctrl;

    localparam int TO    = 4;
    localparam int W     = 8;
    localparam int SAT   = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst, hazard, branch_taken, mem_req, mem_ready;
    logic pc_freeze, if_freeze, if_flush, id_flush, id_freeze;
    logic exe_freeze, mem_freeze, mem_busy, err_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [W-1:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];

    // Reference model state
    logic mdl_busy;
    int   mdl_cnt;
    logic mdl_err;

    // ---- clock / reset ----
    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_freeze    (pc_freeze),
        .if_freeze    (if_freeze),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .id_freeze    (id_freeze),
        .exe_freeze   (exe_freeze),
        .mem_freeze   (mem_freeze),
        .mem_busy     (mem_busy),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .err_timeout  (err_timeout)
    );

    // ---- checker ----
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- drivers ----
    task automatic do_reset();
        rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_busy = 1'b0;
        mdl_cnt  = 0;
        mdl_err  = 1'b0;
    endtask

    // Drive one cycle, queue the expected vector
    // {pc_fz, if_fz, if_fl, id_fl, id_fz, exe_fz, mem_fz, mem_busy, err}, compare, advance model.
    task automatic cycle(input string tag, input logic r, input logic h, input logic b,
                         input logic req, input logic rdy);
        logic       st;
        logic [8:0] e;
        logic [8:0] got;
        rst = r; hazard = h; branch_taken = b; mem_req = req; mem_ready = rdy;
        st = req & ~rdy;
        e = '0;
        if (st)     e[8:2] = 7'b1100111;
        else if (b) e[8:2] = 7'b0011000;
        else if (h) e[8:2] = 7'b1101000;
        e[1] = mdl_busy;
        e[0] = mdl_err;
        exp_q.push_back(e);
        @(negedge clk);
        got = {pc_freeze, if_freeze, if_flush, id_flush, id_freeze,
               exe_freeze, mem_freeze, mem_busy, err_timeout};
        chk(tag, 32'(got), 32'(exp_q.pop_front()));
        if (r) begin
            mdl_busy = 1'b0;
            mdl_cnt  = 0;
            mdl_err  = 1'b0;
        end else begin
            if (mdl_busy && mdl_cnt == TO) mdl_err = 1'b1;
            if (st) mdl_cnt = mdl_busy ? ((mdl_cnt == SAT) ? SAT : mdl_cnt + 1) : 1;
            else    mdl_cnt = 0;
            mdl_busy = st;
        end
        @(posedge clk);
        #1;
    endtask

    // ---- stimulus ----
    initial begin
        do_reset();

        cycle("idle", 0, 0, 0, 0, 0);
        cycle("hazard", 0, 1, 0, 0, 0);
        cycle("after_hazard", 0, 0, 0, 0, 0);
        cycle("hazard_branch", 0, 1, 1, 0, 0);
        cycle("branch_only", 0, 0, 1, 0, 0);

        // 3-cycle memory wait then ready
        repeat (3) cycle("mem_stall", 0, 0, 0, 1, 0);
        cycle("mem_ready", 0, 0, 0, 1, 1);
        cycle("mem_after", 0, 0, 0, 0, 0);
        cycle("mem_1cyc", 0, 0, 0, 1, 1);
        cycle("mem_1cyc_after", 0, 1, 0, 0, 0);

        // branch held across a 2-cycle stall
        repeat (2) cycle("br_in_stall", 0, 0, 1, 1, 0);
        cycle("br_on_ready", 0, 0, 1, 1, 1);
        cycle("br_done", 0, 0, 0, 0, 0);

        // exit by dropping mem_req
        repeat (2) cycle("req_drop_st", 0, 1, 0, 1, 0);
        cycle("req_drop", 0, 1, 0, 0, 0);
        cycle("req_drop_after", 0, 0, 0, 0, 0);

        // watchdog
        repeat (10) cycle("wd_stall", 0, 0, 0, 1, 0);
        cycle("wd_ready", 0, 0, 0, 1, 1);
        repeat (2) cycle("wd_after", 0, 0, 0, 0, 0);
        chk("err_sticky", 32'(err_timeout), 32'd1);
        cycle("wd_rst", 1, 0, 0, 0, 0);
        cycle("wd_post_rst", 0, 0, 0, 0, 0);
        chk("err_cleared", 32'(err_timeout), 32'd0);

        // reset mid-wait
        repeat (3) cycle("rst_mid_st", 0, 0, 0, 1, 0);
        cycle("rst_mid", 1, 0, 0, 1, 0);
        cycle("rst_mid_after", 0, 0, 0, 0, 0);

        // long wait past counter saturation
        repeat (300) cycle("sat_stall", 0, 0, 1, 1, 0);
        cycle("sat_ready", 0, 0, 1, 1, 1);
        cycle("sat_after", 0, 0, 0, 0, 0);
        chk("err_after_sat", 32'(err_timeout), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  logic'($urandom_range(0, 59) == 0),
                  logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 2) != 0));
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // ---- report ----
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
